// File: rtl/mux4_sched_pkg.sv
// Shared constants and state encoding for the four-way round-robin mux scheduler.
package mux4_sched_pkg;

   localparam int unsigned N_REQ = 4;
   localparam int unsigned SEL_W = 2;
   localparam int unsigned CNT_W = 4;

   typedef enum logic {
      S_IDLE,
      S_GRANT
   } state_t;

endpackage

// File: rtl/mux4_rr_sched_if.sv
// Requester-side bus of the scheduler: requests and data in, grant and mux result out.
interface mux4_rr_sched_if;
   import mux4_sched_pkg::*;

   logic             en;
   logic [N_REQ-1:0] req;
   logic [N_REQ-1:0] din;
   logic [N_REQ-1:0] gnt;
   logic [SEL_W-1:0] sel;
   logic             y;
   logic             valid;
   logic             busy;

   modport master (
      output en, req, din,
      input  gnt, sel, y, valid, busy
   );

   modport slave (
      input  en, req, din,
      output gnt, sel, y, valid, busy
   );

endinterface

// File: rtl/rr_pick4.sv
// Combinational round-robin picker: first requester found searching ptr, ptr+1, ... mod 4.
module rr_pick4
   import mux4_sched_pkg::*;
(
   input  logic [N_REQ-1:0] i_req,
   input  logic [SEL_W-1:0] i_ptr,
   output logic [N_REQ-1:0] o_win,
   output logic [SEL_W-1:0] o_index,
   output logic             o_any
);

   logic [SEL_W-1:0] w_idx;

   // Scan from the lowest priority back to ptr so the last hit is the winner.
   always_comb begin
      w_idx   = '0;
      o_index = '0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         w_idx = i_ptr + SEL_W'(k);
         if (i_req[w_idx]) begin
            o_index = w_idx;
         end
      end
   end

   assign o_any = |i_req;
   assign o_win = o_any ? (N_REQ'(1) << o_index) : '0;

endmodule

// File: rtl/mux4_rr_sched.sv
// Round-robin scheduler in front of a 4:1 mux: bounded-burst grants and a registered output bit.
module mux4_rr_sched
   import mux4_sched_pkg::*;
#(
   parameter int unsigned MAX_HOLD = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   mux4_rr_sched_if.slave          s_if
);

   state_t           r_state;
   logic [SEL_W-1:0] r_ptr;
   logic [CNT_W-1:0] r_cnt;
   logic [N_REQ-1:0] r_gnt;
   logic [SEL_W-1:0] r_sel;
   logic             r_y;
   logic             r_valid;
   logic             r_busy;

   logic [N_REQ-1:0] w_win;
   logic [SEL_W-1:0] w_index;
   logic             w_any;
   logic [SEL_W-1:0] w_pick_ptr;
   logic             w_expire;
   logic             w_drop;

   // On a release the rotated pointer (sel+1) must already apply to the same-edge re-arbitration.
   assign w_pick_ptr = (r_state == S_GRANT) ? r_sel + SEL_W'(1) : r_ptr;
   assign w_expire   = (r_cnt + CNT_W'(1)) == CNT_W'(MAX_HOLD);
   assign w_drop     = ~s_if.req[r_sel];

   rr_pick4 u_pick (
      .i_req   (s_if.req),
      .i_ptr   (w_pick_ptr),
      .o_win   (w_win),
      .o_index (w_index),
      .o_any   (w_any)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_ptr   <= '0;
         r_cnt   <= '0;
         r_gnt   <= '0;
         r_sel   <= '0;
         r_y     <= 1'b0;
         r_valid <= 1'b0;
         r_busy  <= 1'b0;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               r_valid <= 1'b0;
               if (s_if.en && w_any) begin
                  r_gnt   <= w_win;
                  r_sel   <= w_index;
                  r_cnt   <= '0;
                  r_state <= S_GRANT;
                  r_busy  <= 1'b1;
               end else begin
                  r_gnt <= '0;
               end
            end
            S_GRANT: begin
               if (!s_if.en) begin
                  r_valid <= 1'b0;
                  r_gnt   <= '0;
                  r_ptr   <= r_sel + SEL_W'(1);
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
               end else begin
                  if (w_drop) begin
                     r_valid <= 1'b0;
                  end else begin
                     r_y     <= s_if.din[r_sel];
                     r_valid <= 1'b1;
                     r_cnt   <= r_cnt + CNT_W'(1);
                  end
                  // A dropped request releases without capture even if the hold also expired.
                  if (w_drop || w_expire) begin
                     r_ptr <= r_sel + SEL_W'(1);
                     if (w_any) begin
                        r_gnt <= w_win;
                        r_sel <= w_index;
                        r_cnt <= '0;
                     end else begin
                        r_gnt   <= '0;
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                     end
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign s_if.gnt   = r_gnt;
   assign s_if.sel   = r_sel;
   assign s_if.y     = r_y;
   assign s_if.valid = r_valid;
   assign s_if.busy  = r_busy;

endmodule

// File: tb/tb_mux4_rr_sched.sv
// Directed bench for mux4_rr_sched with MAX_HOLD=4; obs packs {gnt, sel, y, valid, busy}.
module tb_mux4_rr_sched;

   logic clk;
   logic rst_n;
   int   n_tests;
   int   n_fail;

   mux4_rr_sched_if tb_if ();

   mux4_rr_sched #(
      .MAX_HOLD (4)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .s_if  (tb_if.slave)
   );

   logic [8:0] obs;
   assign obs = {tb_if.gnt, tb_if.sel, tb_if.y, tb_if.valid, tb_if.busy};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      tb_if.en  = 1'b0;
      tb_if.req = 4'b0000;
      tb_if.din = 4'b0000;
      rst_n     = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_reset();
      tb_if.en  = 1'b0;
      tb_if.req = 4'b0000;
      tb_if.din = 4'b0000;
      rst_n     = 1'b0;
      tick();
      n_tests++;
      if (obs !== 9'b0000_00_0_0_0) begin
         $display("FAIL reset_state: got %b expected %b", obs, 9'b0000_00_0_0_0);
         n_fail++;
      end
      rst_n = 1'b1;
      tick();
      n_tests++;
      if (obs !== 9'b0000_00_0_0_0) begin
         $display("FAIL reset_idle: got %b expected %b", obs, 9'b0000_00_0_0_0);
         n_fail++;
      end
   endtask

   task automatic test_single();
      do_reset();
      tb_if.en  = 1'b1;
      tb_if.req = 4'b0010;
      tb_if.din = 4'b0010;
      tick();
      n_tests++;
      if (obs !== {4'b0010, 2'd1, 1'b0, 1'b0, 1'b1}) begin
         $display("FAIL single_grant: got %b expected %b", obs, {4'b0010, 2'd1, 3'b001});
         n_fail++;
      end
      // Four captures, regrant of the same requester on the last, then a fifth with no gap.
      for (int c = 0; c < 5; c++) begin
         tick();
         n_tests++;
         if (obs !== {4'b0010, 2'd1, 1'b1, 1'b1, 1'b1}) begin
            $display("FAIL single_burst[%0d]: got %b expected %b", c, obs, {4'b0010, 2'd1, 3'b111});
            n_fail++;
         end
      end
      tb_if.req = 4'b0000;
      tick();
      n_tests++;
      if (obs !== {4'b0000, 2'd1, 1'b1, 1'b0, 1'b0}) begin
         $display("FAIL single_release: got %b expected %b", obs, {4'b0000, 2'd1, 3'b100});
         n_fail++;
      end
   endtask

   task automatic test_fairness();
      logic [3:0] dv;
      logic [3:0] eg;
      logic [1:0] es;
      do_reset();
      dv        = 4'b0101;
      tb_if.en  = 1'b1;
      tb_if.req = 4'b1111;
      tb_if.din = dv;
      tick();
      n_tests++;
      if (obs !== {4'b0001, 2'd0, 1'b0, 1'b0, 1'b1}) begin
         $display("FAIL fair_first: got %b expected %b", obs, {4'b0001, 2'd0, 3'b001});
         n_fail++;
      end
      for (int g = 0; g < 5; g++) begin
         for (int c = 0; c < 4; c++) begin
            tick();
            es = (c == 3) ? 2'((g + 1) % 4) : 2'(g % 4);
            eg = 4'b0001 << es;
            n_tests++;
            if (obs !== {eg, es, dv[g % 4], 1'b1, 1'b1}) begin
               $display("FAIL fair_g%0d_c%0d: got %b expected %b", g, c, obs,
                        {eg, es, dv[g % 4], 2'b11});
               n_fail++;
            end
         end
      end
   endtask

   task automatic test_early_drop();
      do_reset();
      tb_if.en  = 1'b1;
      tb_if.req = 4'b0100;
      tb_if.din = 4'b0100;
      tick();
      n_tests++;
      if (obs !== {4'b0100, 2'd2, 1'b0, 1'b0, 1'b1}) begin
         $display("FAIL drop_grant: got %b expected %b", obs, {4'b0100, 2'd2, 3'b001});
         n_fail++;
      end
      for (int c = 0; c < 2; c++) begin
         tick();
         n_tests++;
         if (obs !== {4'b0100, 2'd2, 1'b1, 1'b1, 1'b1}) begin
            $display("FAIL drop_capture[%0d]: got %b expected %b", c, obs, {4'b0100, 2'd2, 3'b111});
            n_fail++;
         end
      end
      tb_if.req = 4'b1000;
      tick();
      n_tests++;
      if (obs !== {4'b1000, 2'd3, 1'b1, 1'b0, 1'b1}) begin
         $display("FAIL drop_next_grant: got %b expected %b", obs, {4'b1000, 2'd3, 3'b101});
         n_fail++;
      end
      tick();
      n_tests++;
      if (obs !== {4'b1000, 2'd3, 1'b0, 1'b1, 1'b1}) begin
         $display("FAIL drop_next_capture: got %b expected %b", obs, {4'b1000, 2'd3, 3'b011});
         n_fail++;
      end
      tb_if.req = 4'b0000;
      tick();
      n_tests++;
      if (obs !== {4'b0000, 2'd3, 1'b0, 1'b0, 1'b0}) begin
         $display("FAIL drop_to_idle: got %b expected %b", obs, {4'b0000, 2'd3, 3'b000});
         n_fail++;
      end
   endtask

   task automatic test_enable();
      do_reset();
      tb_if.en  = 1'b1;
      tb_if.req = 4'b0001;
      tb_if.din = 4'b0001;
      tick();
      tick();
      n_tests++;
      if (obs !== {4'b0001, 2'd0, 1'b1, 1'b1, 1'b1}) begin
         $display("FAIL en_capture: got %b expected %b", obs, {4'b0001, 2'd0, 3'b111});
         n_fail++;
      end
      tb_if.en  = 1'b0;
      tb_if.req = 4'b1111;
      for (int c = 0; c < 3; c++) begin
         tick();
         n_tests++;
         if (obs !== {4'b0000, 2'd0, 1'b1, 1'b0, 1'b0}) begin
            $display("FAIL en_off[%0d]: got %b expected %b", c, obs, {4'b0000, 2'd0, 3'b100});
            n_fail++;
         end
      end
      tb_if.en = 1'b1;
      tick();
      n_tests++;
      if (obs !== {4'b0010, 2'd1, 1'b1, 1'b0, 1'b1}) begin
         $display("FAIL en_resume: got %b expected %b", obs, {4'b0010, 2'd1, 3'b101});
         n_fail++;
      end
   endtask

   task automatic test_datapath();
      logic [3:0] bits;
      logic [2:0] junk [4];
      bits    = 4'b1101;
      junk[0] = 3'b111;
      junk[1] = 3'b000;
      junk[2] = 3'b101;
      junk[3] = 3'b010;
      do_reset();
      tb_if.en  = 1'b1;
      tb_if.req = 4'b1000;
      tb_if.din = 4'b1000;
      tick();
      n_tests++;
      if (obs !== {4'b1000, 2'd3, 1'b0, 1'b0, 1'b1}) begin
         $display("FAIL data_grant: got %b expected %b", obs, {4'b1000, 2'd3, 3'b001});
         n_fail++;
      end
      for (int i = 0; i < 4; i++) begin
         tb_if.din = {bits[3 - i], junk[i]};
         tick();
         n_tests++;
         if (obs !== {4'b1000, 2'd3, bits[3 - i], 1'b1, 1'b1}) begin
            $display("FAIL data_y[%0d]: got %b expected %b", i, obs,
                     {4'b1000, 2'd3, bits[3 - i], 2'b11});
            n_fail++;
         end
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      tb_if.en  = 1'b1;
      tb_if.req = 4'b0001;
      tb_if.din = 4'b0001;
      tick();
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      n_tests++;
      if (obs !== 9'b0000_00_0_0_0) begin
         $display("FAIL reset_mid: got %b expected %b", obs, 9'b0000_00_0_0_0);
         n_fail++;
      end
      tb_if.req = 4'b0100;
      tick();
      rst_n = 1'b1;
      tick();
      n_tests++;
      if (obs !== {4'b0100, 2'd2, 1'b0, 1'b0, 1'b1}) begin
         $display("FAIL reset_regrant: got %b expected %b", obs, {4'b0100, 2'd2, 3'b001});
         n_fail++;
      end
   endtask

   initial begin
      n_tests   = 0;
      n_fail    = 0;
      rst_n     = 1'b0;
      tb_if.en  = 1'b0;
      tb_if.req = 4'b0000;
      tb_if.din = 4'b0000;
      test_reset();
      test_single();
      test_fairness();
      test_early_drop();
      test_enable();
      test_datapath();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
